// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: load/store unit bridging the execute stage to a ready/ack data bus with alignment and timeout checks.
module data_mem_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en,
  input  logic        mem_rw,
  input  logic [1:0]  dw,
  input  logic        sign_ex,
  input  logic [31:0] mem_write_addr,
  input  logic [31:0] mem_write_data,
  output logic [31:0] mem_read_data,
  output logic        data_ready,
  output logic        misalign,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [1:0] r_dw, r_lane;
  logic r_sx, w_mis, w_tout;
  logic [3:0] w_be;
  logic [31:0] w_wdata, w_sh, w_load;
  always_comb begin
    w_mis = (dw == 2'd1 && mem_write_addr[0]) || (dw[1] && mem_write_addr[1:0] != 2'b00);
    w_be = dw == 2'd0 ? 4'b0001 << mem_write_addr[1:0] :
           dw == 2'd1 ? 4'b0011 << mem_write_addr[1:0] : 4'b1111;
    w_wdata = dw == 2'd0 ? {4{mem_write_data[7:0]}} :
              dw == 2'd1 ? {2{mem_write_data[15:0]}} : mem_write_data;
    w_tout = r_cnt == CW'(TIMEOUT - 1);
    w_sh = bus_rdata >> {r_lane, 3'b000};
    w_load = r_dw == 2'd0 ? {{24{w_sh[7] & r_sx}}, w_sh[7:0]} :
             r_dw == 2'd1 ? {{16{w_sh[15] & r_sx}}, w_sh[15:0]} : w_sh;
    w_next = r_state == IDLE ? (mem_en ? (w_mis ? DONE : REQ) : IDLE) :
             r_state == REQ  ? ((bus_ack || w_tout) ? DONE : REQ) : IDLE;
    data_ready = r_state == DONE || (r_state == IDLE && !mem_en);
  end
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_dw <= '0;
      r_lane <= '0;
      r_sx <= 1'b0;
      mem_read_data <= '0;
      misalign <= 1'b0;
      bus_err <= 1'b0;
      bus_req <= 1'b0;
      bus_we <= 1'b0;
      bus_addr <= '0;
      bus_be <= '0;
      bus_wdata <= '0;
    end else begin
      misalign <= 1'b0;
      bus_err <= 1'b0;
      if (r_state == IDLE && mem_en) begin
        r_cnt <= '0;
        r_dw <= dw;
        r_lane <= mem_write_addr[1:0];
        r_sx <= sign_ex;
        if (w_mis) begin
          misalign <= 1'b1;
          if (!mem_rw) mem_read_data <= '0;
        end else begin
          bus_req <= 1'b1;
          bus_we <= mem_rw;
          bus_addr <= {mem_write_addr[31:2], 2'b00};
          bus_be <= w_be;
          bus_wdata <= w_wdata;
        end
      end else if (r_state == REQ) begin
        r_cnt <= r_cnt + 1'b1;
        if (bus_ack) begin
          bus_req <= 1'b0;
          if (!bus_we) mem_read_data <= w_load;
        end else if (w_tout) begin
          bus_req <= 1'b0;
          bus_err <= 1'b1;
          if (!bus_we) mem_read_data <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: randomized and directed accesses against a byte-lane reference model.
module tb_data_mem_ctrl;
  localparam int TO = 4;
  logic clk = 1'b0, rst = 1'b1, mem_en = 1'b0, mem_rw = 1'b0, sign_ex = 1'b0, bus_ack = 1'b0;
  logic [1:0] dw = '0;
  logic [31:0] mem_write_addr = '0, mem_write_data = '0, bus_rdata = '0;
  logic [31:0] mem_read_data, bus_addr, bus_wdata;
  logic data_ready, misalign, bus_err, bus_req, bus_we;
  logic [3:0] bus_be;
  logic [31:0] exp_rd = '0;
  int n_chk = 0, n_err = 0;
  always #5 clk = ~clk;
  data_mem_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .mem_en(mem_en), .mem_rw(mem_rw), .dw(dw), .sign_ex(sign_ex),
    .mem_write_addr(mem_write_addr), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .data_ready(data_ready), .misalign(misalign),
    .bus_err(bus_err), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic access(input logic rw, input logic [1:0] d, input logic sx,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd, input int dly);
    int size, lane;
    logic mis, tout;
    logic [3:0] ebe;
    logic [31:0] ewd, val;
    size = d == 2'd0 ? 1 : d == 2'd1 ? 2 : 4;
    lane = int'(a % 4);
    mis = (a % size) != 0;
    tout = dly >= TO;
    for (int i = 0; i < 4; i++) begin
      ebe[i] = i >= lane && i < lane + size;
      ewd[8*i +: 8] = wd[8*(i % size) +: 8];
    end
    val = rd >> (8 * lane);
    if (size < 4) begin
      val = val % (32'd1 << (8 * size));
      if (sx && val >= (32'd1 << (8 * size - 1))) val = val - (32'd1 << (8 * size));
    end
    mem_en = 1'b1; mem_rw = rw; dw = d; sign_ex = sx; mem_write_addr = a; mem_write_data = wd;
    #1 check("stall", 32'(data_ready), 32'd0);
    if (mis) begin
      step();
      check("mis_pulse", 32'(misalign), 32'd1);
      check("mis_nobus", 32'(bus_req), 32'd0);
      check("mis_ready", 32'(data_ready), 32'd1);
      if (!rw) exp_rd = '0;
    end else begin
      for (int c = 0; c < TO; c++) begin
        step();
        check("req", 32'(bus_req), 32'd1);
        check("req_ready", 32'(data_ready), 32'd0);
        check("bus_addr", bus_addr, a & 32'hFFFF_FFFC);
        check("bus_be", 32'(bus_be), 32'(ebe));
        check("bus_we", 32'(bus_we), 32'(rw));
        if (rw) check("bus_wdata", bus_wdata, ewd);
        check("rd_hold", mem_read_data, exp_rd);
        bus_ack = c == dly;
        bus_rdata = c == dly ? rd : $urandom;
        if (c == dly) break;
      end
      step();
      bus_ack = 1'b0;
      check("done_ready", 32'(data_ready), 32'd1);
      check("done_req", 32'(bus_req), 32'd0);
      check("bus_err", 32'(bus_err), 32'(tout));
      check("no_mis", 32'(misalign), 32'd0);
      if (!rw) exp_rd = tout ? '0 : val;
    end
    check("rd", mem_read_data, exp_rd);
    mem_en = 1'b0;
    bus_ack = $urandom_range(0, 1);
    step();
    bus_ack = 1'b0;
    check("pulse_end", 32'({misalign, bus_err, bus_req}), 32'd0);
    check("idle_ready", 32'(data_ready), 32'd1);
    check("rd_idle", mem_read_data, exp_rd);
  endtask
  initial begin
    repeat (3) step();
    check("rst_bus", 32'({bus_req, bus_we, bus_be, misalign, bus_err}), 32'd0);
    check("rst_addr", bus_addr, 32'd0);
    check("rst_wdata", bus_wdata, 32'd0);
    check("rst_rd", mem_read_data, 32'd0);
    rst = 1'b0;
    step();
    check("rst_ready", 32'(data_ready), 32'd1);
    access(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h80FF_0000, 0);
    check("lb_sext", mem_read_data, 32'hFFFF_FF80);
    access(1'b1, 2'd1, 1'b0, 32'h202, 32'h0000_ABCD, 32'h0, 1);
    access(1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 32'h0, 0);
    check("mis_zero", mem_read_data, 32'd0);
    access(1'b0, 2'd1, 1'b0, 32'h0, 32'h0, 32'h1234_F00D, 3);
    check("lh_zext", mem_read_data, 32'h0000_F00D);
    access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 6);
    check("tout_zero", mem_read_data, 32'd0);
    for (int k = 0; k < 60; k++) begin
      logic [31:0] ra;
      ra = $urandom;
      if ($urandom_range(0, 3) != 0) ra[1:0] = ($urandom_range(0, 1) != 0) ? 2'b00 : ra[1:0] & 2'b10;
      access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             ra, $urandom, $urandom, $urandom_range(0, 5));
    end
    access(1'b0, 2'd2, 1'b0, 32'h80, 32'h0, 32'h1357_9BDF, 0);
    mem_en = 1'b1; mem_rw = 1'b0; dw = 2'd2; mem_write_addr = 32'h40;
    step();
    step();
    rst = 1'b1; mem_en = 1'b0;
    step();
    rst = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    check("mid_rst_req", 32'({bus_req, bus_we, bus_be}), 32'd0);
    check("mid_rst_addr", bus_addr, 32'd0);
    check("mid_rst_rd", mem_read_data, 32'd0);
    step();
    bus_ack = 1'b0;
    check("late_ack", 32'({bus_req, bus_err, misalign}), 32'd0);
    check("late_ready", 32'(data_ready), 32'd1);
    check("late_rd", mem_read_data, 32'd0);
    exp_rd = '0;
    rst = 1'b1; mem_en = 1'b1; mem_write_addr = 32'h44; bus_ack = 1'b1;
    step();
    check("rst_dom", 32'(bus_req), 32'd0);
    rst = 1'b0; mem_en = 1'b0; bus_ack = 1'b0;
    step();
    check("rst_dom_idle", 32'({bus_req, data_ready}), 32'd1);
    access(1'b0, 2'd0, 1'b0, 32'h1, 32'h0, 32'h0000_A500, 2);
    check("lbu", mem_read_data, 32'h0000_00A5);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
